fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues word reads to the instruction memory, and presents fetched instructions with their PC to the decoder through a valid/ready handshake. A 2-entry output buffer absorbs the one-cycle memory latency, so decode back-pressure never loses an in-flight word. Redirect (branch/jump/restart) discards all buffered and in-flight words and restarts fetch at a new PC. It sits directly upstream of the instruction register and decoder.

## Interface

- PC_BASE_ADDR, 32'h80020000, PC loaded at reset; memory word address = PC − PC_BASE_ADDR
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising clock edge
- imem_en  out  1  read request to instruction memory this cycle
- w_imem_addr_32  out  32  PC − PC_BASE_ADDR (mod 2^32), valid when imem_en=1
- w_imem_data_in_32  in  32  memory read data, valid exactly one cycle after the imem_en cycle
- instr_valid  out  1  buffer head holds a valid instruction
- decode_ready  in  1  decoder accepts head this cycle
- w_instr_out_32  out  32  head instruction word
- w_pc_out_32  out  32  PC of head instruction
- redirect  in  1  restart fetch at w_redirect_pc_32
- w_redirect_pc_32  in  32  new PC
- misalign_err  out  1  sticky: a redirect PC had bits[1:0] ≠ 0
- w_retired_count_32  out  32  count of instructions accepted by decode

## Operation

- Registered state: PC, inflight (1 bit, plus its PC), 2-entry FIFO (instr, pc), count ∈ {0,1,2}, misalign_err, retired counter.
- Buffer states: EMPTY (count 0), ONE (1), FULL (2). Transitions at each edge: count' = count + capture − pop; redirect forces EMPTY.
- pop = instr_valid & decode_ready. instr_valid = (count ≠ 0). Head outputs are FIFO head entry; zero when EMPTY.
- issue (combinational) = reset_n & ~redirect & (count + inflight − pop < 2). imem_en = issue; w_imem_addr_32 = PC − PC_BASE_ADDR.
- On issue: PC' = PC + 4 (wraps 32'hFFFFFFFC → 0), inflight' = 1 with PC recorded; else inflight' = 0.
- capture = inflight & ~redirect: w_imem_data_in_32 and recorded PC written to FIFO tail at that edge.
- redirect (priority over issue/capture): FIFO cleared, inflight' = 0, in-arrival word discarded, PC' = {w_redirect_pc_32[31:2], 2'b00}; if w_redirect_pc_32[1:0] ≠ 0, misalign_err' = 1 (stays 1 until reset).
- Pop during redirect cycle still counts as retired (decoder took it).
- w_retired_count_32 increments on pop, wraps at 2^32.
- Simultaneous pop and capture in FULL cannot occur (issue rule bounds count+inflight ≤ 2); in ONE, pop+capture keeps count=1.

## Timing

- Reset (reset=0 at edge): PC=PC_BASE_ADDR, count=0, inflight=0, misalign_err=0, retired=0. During reset cycles imem_en=0, instr_valid=0, w_instr_out_32=0, w_pc_out_32=0.
- Reset mid-operation discards everything identically to power-up; no partial completion.
- First cycle with reset=1 (cycle 0): imem_en=1, addr 0. Data arrives cycle 1, captured end of cycle 1; instr_valid=1 in cycle 2 with pc=PC_BASE_ADDR. Fetch-to-output latency 2 cycles.
- decode_ready held 1: one instruction per cycle sustained, consecutive PCs +4.
- decode_ready low: at most 2 words buffered; imem_en drops once count+inflight=2; no word lost or duplicated; resumes issue in the same cycle decode_ready returns.
- Redirect at cycle N: imem_en=0 in N; instr_valid=0 in N+1; imem_en=1 at redirect PC in N+1; first redirected instr valid in N+3.
- Back-to-back redirects: last one wins; each forces EMPTY.

## Test plan

- Reset release, decode_ready=1, memory word k = k: instr_valid first in cycle 2, outputs (0x00000000, 0x80020000), (1, 0x80020004), … one per cycle; retired count matches pops.
- decode_ready low cycles 3–7 then high: buffer FULL with PCs 0x80020004/…08 held, imem_en=0 during stall, sequence resumes gap-free and without duplicates.
- Redirect to 0x80020100 while FULL and inflight: next cycle instr_valid=0, imem addr 0x100 issued, first output pc 0x80020100 two cycles later; stale words never appear.
- Redirect to 0x80020102: PC becomes 0x80020100, misalign_err=1 and stays 1 until reset=0 applied.
- Reset=0 asserted mid-stream with FULL buffer: following cycle all outputs zero, imem_en=0; after release, fetch restarts at 0x80020000.
- Redirect to 0xFFFFFFFC (PC_BASE_ADDR=0): outputs pc 0xFFFFFFFC then 0x00000000, address wraps correctly.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, decode handshake, redirect
// and status. master = fetch_stage, slave = memory/decoder/control side.
interface fetch_stage_if;
    logic        imem_en;
    logic [31:0] w_imem_addr_32;
    logic [31:0] w_imem_data_in_32;
    logic        instr_valid;
    logic        decode_ready;
    logic [31:0] w_instr_out_32;
    logic [31:0] w_pc_out_32;
    logic        redirect;
    logic [31:0] w_redirect_pc_32;
    logic        misalign_err;
    logic [31:0] w_retired_count_32;

    modport master (
        output imem_en,
        output w_imem_addr_32,
        input  w_imem_data_in_32,
        output instr_valid,
        input  decode_ready,
        output w_instr_out_32,
        output w_pc_out_32,
        input  redirect,
        input  w_redirect_pc_32,
        output misalign_err,
        output w_retired_count_32
    );

    modport slave (
        input  imem_en,
        input  w_imem_addr_32,
        output w_imem_data_in_32,
        input  instr_valid,
        output decode_ready,
        input  w_instr_out_32,
        input  w_pc_out_32,
        output redirect,
        output w_redirect_pc_32,
        input  misalign_err,
        input  w_retired_count_32
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-cycle-latency imem reads, 2-entry output FIFO.
// Ports: clock, reset (sync, active-low), bus (fetch_stage_if.master).
module fetch_stage #(
    parameter logic [31:0] PC_BASE_ADDR = 32'h80020000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        misalign_q, misalign_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] instr_q [2];
    logic [31:0] ipc_q   [2];

    logic        valid;
    logic        pop;
    logic        capture;
    logic        issue;
    logic [2:0]  occ;
    logic        wr_idx;

    assign valid   = (count_q != EMPTY);
    assign pop     = valid & bus.decode_ready;
    // Slots already committed after this cycle's pop; never issue past 2.
    assign occ     = {1'b0, count_q} + {2'b00, inflight_q}
                   - {2'b00, pop};
    assign issue   = reset & ~bus.redirect & (occ < 3'd2);
    assign capture = inflight_q & ~bus.redirect;
    // Tail slot; FULL never captures, so only EMPTY/ONE matter.
    assign wr_idx  = (count_q == ONE) ? ~head_q : head_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q + {1'b0, capture} - {1'b0, pop};
        head_d        = head_q ^ pop;
        misalign_d    = misalign_q;
        retired_d     = retired_q + {31'd0, pop};
        if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
        if (bus.redirect) begin
            pc_d       = {bus.w_redirect_pc_32[31:2], 2'b00};
            inflight_d = 1'b0;
            count_d    = EMPTY;
            head_d     = 1'b0;
            if (bus.w_redirect_pc_32[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q          <= PC_BASE_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            count_q       <= EMPTY;
            head_q        <= 1'b0;
            misalign_q    <= 1'b0;
            retired_q     <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            misalign_q    <= misalign_d;
            retired_q     <= retired_d;
        end
    end

    // Payload needs no reset: head outputs are masked while EMPTY.
    always_ff @(posedge clock) begin
        if (reset && capture) begin
            instr_q[wr_idx] <= bus.w_imem_data_in_32;
            ipc_q[wr_idx]   <= inflight_pc_q;
        end
    end

    assign bus.imem_en            = issue;
    assign bus.w_imem_addr_32     = pc_q - PC_BASE_ADDR;
    assign bus.instr_valid        = valid;
    assign bus.w_instr_out_32     = valid ? instr_q[head_q] : 32'd0;
    assign bus.w_pc_out_32        = valid ? ipc_q[head_q] : 32'd0;
    assign bus.misalign_err       = misalign_q;
    assign bus.w_retired_count_32 = retired_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table on the default
// base, plus an address-wrap sequence on a PC_BASE_ADDR=0 instance.
module tb_fetch_stage;
    localparam logic [31:0] B = 32'h80020000;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_stage_if if1 ();
    fetch_stage_if if2 ();

    fetch_stage #(.PC_BASE_ADDR(B)) u_dut1 (
        .clock(clk),
        .reset(rst1),
        .bus  (if1.master)
    );

    fetch_stage #(.PC_BASE_ADDR(32'd0)) u_dut2 (
        .clock(clk),
        .reset(rst2),
        .bus  (if2.master)
    );

    // Memory word at byte address 4k holds k; one-cycle read latency.
    always @(posedge clk) begin
        if1.w_imem_data_in_32 <= if1.imem_en ?
            {2'b00, if1.w_imem_addr_32[31:2]} : 32'hDEADBEEF;
        if2.w_imem_data_in_32 <= if2.imem_en ?
            {2'b00, if2.w_imem_addr_32[31:2]} : 32'hDEADBEEF;
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] ret;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic rst, input logic rdy, input logic rd,
        input logic [31:0] rpc, input logic en, input logic [31:0] addr,
        input logic v, input logic [31:0] ins, input logic [31:0] pc,
        input logic mis, input logic [31:0] ret);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.rd = rd; r.rpc = rpc;
        r.en = en; r.addr = addr; r.v = v; r.ins = ins;
        r.pc = pc; r.mis = mis; r.ret = ret;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        rst1 = 1'b0;
        rst2 = 1'b0;
        if1.decode_ready = 1'b0;
        if1.redirect = 1'b0;
        if1.w_redirect_pc_32 = 32'd0;
        if2.decode_ready = 1'b0;
        if2.redirect = 1'b0;
        if2.w_redirect_pc_32 = 32'd0;

        //            rst rdy rd rpc       en addr    v ins    pc        mis ret
        tv.push_back(mk(0, 1, 0, 0,        0, 0,      0, 0,    0,        0, 0));
        tv.push_back(mk(1, 1, 0, 0,        1, 0,      0, 0,    0,        0, 0));
        tv.push_back(mk(1, 1, 0, 0,        1, 4,      0, 0,    0,        0, 0));
        tv.push_back(mk(1, 1, 0, 0,        1, 8,      1, 0,    B,        0, 0));
        for (int k = 0; k < 5; k++)
            tv.push_back(mk(1, 0, 0, 0,    0, 0,      1, 1,    B+4,      0, 1));
        tv.push_back(mk(1, 1, 0, 0,        1, 'hC,    1, 1,    B+4,      0, 1));
        tv.push_back(mk(1, 1, 0, 0,        1, 'h10,   1, 2,    B+8,      0, 2));
        tv.push_back(mk(1, 0, 0, 0,        0, 0,      1, 3,    B+'hC,    0, 3));
        tv.push_back(mk(1, 1, 1, B+'h100,  0, 0,      1, 3,    B+'hC,    0, 3));
        tv.push_back(mk(1, 1, 0, 0,        1, 'h100,  0, 0,    0,        0, 4));
        tv.push_back(mk(1, 1, 0, 0,        1, 'h104,  0, 0,    0,        0, 4));
        tv.push_back(mk(1, 1, 0, 0,        1, 'h108,  1, 'h40, B+'h100,  0, 4));
        tv.push_back(mk(1, 1, 1, B+'h102,  0, 0,      1, 'h41, B+'h104,  0, 5));
        tv.push_back(mk(1, 0, 0, 0,        1, 'h100,  0, 0,    0,        1, 6));
        tv.push_back(mk(1, 0, 0, 0,        1, 'h104,  0, 0,    0,        1, 6));
        tv.push_back(mk(1, 0, 0, 0,        0, 0,      1, 'h40, B+'h100,  1, 6));
        tv.push_back(mk(1, 0, 0, 0,        0, 0,      1, 'h40, B+'h100,  1, 6));
        tv.push_back(mk(0, 0, 0, 0,        0, 0,      1, 'h40, B+'h100,  1, 6));
        tv.push_back(mk(0, 1, 0, 0,        0, 0,      0, 0,    0,        0, 0));
        tv.push_back(mk(1, 1, 0, 0,        1, 0,      0, 0,    0,        0, 0));
        tv.push_back(mk(1, 1, 0, 0,        1, 4,      0, 0,    0,        0, 0));
        tv.push_back(mk(1, 1, 0, 0,        1, 8,      1, 0,    B,        0, 0));

        repeat (2) @(posedge clk);

        foreach (tv[i]) begin
            @(posedge clk);
            #1;
            rst1 = tv[i].rst;
            if1.decode_ready = tv[i].rdy;
            if1.redirect = tv[i].rd;
            if1.w_redirect_pc_32 = tv[i].rpc;
            @(negedge clk);
            chk($sformatf("v%0d.en", i), {31'd0, if1.imem_en},
                {31'd0, tv[i].en});
            if (tv[i].en)
                chk($sformatf("v%0d.addr", i), if1.w_imem_addr_32,
                    tv[i].addr);
            chk($sformatf("v%0d.valid", i), {31'd0, if1.instr_valid},
                {31'd0, tv[i].v});
            chk($sformatf("v%0d.instr", i), if1.w_instr_out_32, tv[i].ins);
            chk($sformatf("v%0d.pc", i), if1.w_pc_out_32, tv[i].pc);
            chk($sformatf("v%0d.mis", i), {31'd0, if1.misalign_err},
                {31'd0, tv[i].mis});
            chk($sformatf("v%0d.ret", i), if1.w_retired_count_32,
                tv[i].ret);
        end

        // Wrap: redirect to the top word with base 0, then fall through 0.
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        if2.decode_ready = 1'b1;
        if2.redirect = 1'b1;
        if2.w_redirect_pc_32 = 32'hFFFFFFFC;
        @(negedge clk);
        chk("wrap.c0.en", {31'd0, if2.imem_en}, 32'd0);
        @(posedge clk);
        #1;
        if2.redirect = 1'b0;
        @(negedge clk);
        chk("wrap.c1.en", {31'd0, if2.imem_en}, 32'd1);
        chk("wrap.c1.addr", if2.w_imem_addr_32, 32'hFFFFFFFC);
        chk("wrap.c1.valid", {31'd0, if2.instr_valid}, 32'd0);
        @(negedge clk);
        chk("wrap.c2.en", {31'd0, if2.imem_en}, 32'd1);
        chk("wrap.c2.addr", if2.w_imem_addr_32, 32'h00000000);
        @(negedge clk);
        chk("wrap.c3.valid", {31'd0, if2.instr_valid}, 32'd1);
        chk("wrap.c3.instr", if2.w_instr_out_32, 32'h3FFFFFFF);
        chk("wrap.c3.pc", if2.w_pc_out_32, 32'hFFFFFFFC);
        @(negedge clk);
        chk("wrap.c4.valid", {31'd0, if2.instr_valid}, 32'd1);
        chk("wrap.c4.instr", if2.w_instr_out_32, 32'h00000000);
        chk("wrap.c4.pc", if2.w_pc_out_32, 32'h00000000);
        chk("wrap.c4.ret", if2.w_retired_count_32, 32'd1);
        chk("wrap.c4.mis", {31'd0, if2.misalign_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
